// File: rtl/sdram_wide_port.sv
// Bridges one 128-bit request to eight 16-bit Avalon-MM beats (writes) or pipelined reads.
// Optional build macro WIDE_PORT_BE_SKIP_EN: skip write beats whose byte enables are both zero.
module sdram_wide_port (
    input  logic         clk,
    input  logic         reset,
    input  logic [21:0]  req_addr,
    input  logic [15:0]  req_be,
    input  logic         req_read,
    input  logic         req_write,
    input  logic [127:0] req_wrdata,
    output logic         req_ac,
    output logic [127:0] req_rddata,
    output logic [24:0]  avm_address,
    output logic [1:0]   avm_byteenable,
    output logic         avm_read,
    output logic         avm_write,
    output logic [15:0]  avm_writedata,
    input  logic [15:0]  avm_readdata,
    input  logic         avm_readdatavalid,
    input  logic         avm_waitrequest
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_BEAT  = 3'd1,
        RD_ISSUE = 3'd2,
        RD_DRAIN = 3'd3,
        ACK      = 3'd4
    } state_t;

`ifdef WIDE_PORT_BE_SKIP_EN
    localparam logic SKIP_EN = 1'b1;
`else
    localparam logic SKIP_EN = 1'b0;
`endif

    state_t         state_r;
    logic [21:0]    addr_r;
    logic [15:0]    be_r;
    logic [127:0]   wrdata_r;
    logic [2:0]     beat_r;
    logic [2:0]     ret_r;
    logic [111:0]   rdbuf_r;
    logic [3:0]     first_beat_s;
    logic [3:0]     next_beat_s;

    function automatic logic [1:0] beat_be(input logic [15:0] be, input logic [2:0] b);
        return be[{b, 1'b0} +: 2];
    endfunction

    function automatic logic [15:0] beat_data(input logic [127:0] d, input logic [2:0] b);
        return d[{b, 4'b0000} +: 16];
    endfunction

    // First write beat at or after 'from'; value 8 means no beat is left to issue.
    function automatic logic [3:0] next_write_beat(input logic [15:0] be, input logic [3:0] from);
        logic [3:0] nxt;
        nxt = 4'd8;
        if (SKIP_EN) begin
            for (int i = 7; i >= 0; i--) begin
                if ((4'(i) >= from) && (be[2*i +: 2] != 2'b00)) begin
                    nxt = 4'(i);
                end else begin
                    nxt = nxt;
                end
            end
        end else begin
            nxt = from;
        end
        return nxt;
    endfunction

    // Beat selection for the incoming request and for the beat after the current one.
    always_comb begin
        first_beat_s = next_write_beat(req_be, 4'd0);
        next_beat_s  = next_write_beat(be_r, {1'b0, beat_r} + 4'd1);
    end

    // Transaction FSM with all bus and requester outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            addr_r         <= 22'd0;
            be_r           <= 16'd0;
            wrdata_r       <= 128'd0;
            beat_r         <= 3'd0;
            ret_r          <= 3'd0;
            rdbuf_r        <= 112'd0;
            req_ac         <= 1'b0;
            req_rddata     <= 128'd0;
            avm_address    <= 25'd0;
            avm_byteenable <= 2'b00;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= 16'd0;
        end else begin
            req_ac <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_write) begin
                        addr_r   <= req_addr;
                        be_r     <= req_be;
                        wrdata_r <= req_wrdata;
                        if (first_beat_s[3]) begin
                            state_r <= ACK;
                            req_ac  <= 1'b1;
                        end else begin
                            state_r        <= WR_BEAT;
                            beat_r         <= first_beat_s[2:0];
                            avm_write      <= 1'b1;
                            avm_address    <= {req_addr, first_beat_s[2:0]};
                            avm_byteenable <= beat_be(req_be, first_beat_s[2:0]);
                            avm_writedata  <= beat_data(req_wrdata, first_beat_s[2:0]);
                        end
                    end else if (req_read) begin
                        state_r        <= RD_ISSUE;
                        addr_r         <= req_addr;
                        beat_r         <= 3'd0;
                        ret_r          <= 3'd0;
                        avm_read       <= 1'b1;
                        avm_address    <= {req_addr, 3'd0};
                        avm_byteenable <= 2'b11;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WR_BEAT: begin
                    if (!avm_waitrequest) begin
                        if (next_beat_s[3]) begin
                            state_r        <= ACK;
                            req_ac         <= 1'b1;
                            avm_write      <= 1'b0;
                            avm_byteenable <= 2'b00;
                        end else begin
                            beat_r         <= next_beat_s[2:0];
                            avm_address    <= {addr_r, next_beat_s[2:0]};
                            avm_byteenable <= beat_be(be_r, next_beat_s[2:0]);
                            avm_writedata  <= beat_data(wrdata_r, next_beat_s[2:0]);
                        end
                    end else begin
                        state_r <= WR_BEAT;
                    end
                end
                RD_ISSUE: begin
                    if (avm_readdatavalid) begin
                        rdbuf_r <= {avm_readdata, rdbuf_r[111:16]};
                        ret_r   <= ret_r + 3'd1;
                    end else begin
                        ret_r <= ret_r;
                    end
                    if (!avm_waitrequest) begin
                        if (beat_r == 3'd7) begin
                            state_r        <= RD_DRAIN;
                            avm_read       <= 1'b0;
                            avm_byteenable <= 2'b00;
                        end else begin
                            beat_r      <= beat_r + 3'd1;
                            avm_address <= {addr_r, beat_r + 3'd1};
                        end
                    end else begin
                        beat_r <= beat_r;
                    end
                    // Zero-latency slaves can return the last halfword before the drain phase.
                    if (avm_readdatavalid && (ret_r == 3'd7)) begin
                        state_r        <= ACK;
                        req_ac         <= 1'b1;
                        avm_read       <= 1'b0;
                        avm_byteenable <= 2'b00;
                        req_rddata     <= {avm_readdata, rdbuf_r};
                    end else begin
                        req_rddata <= req_rddata;
                    end
                end
                RD_DRAIN: begin
                    if (avm_readdatavalid) begin
                        rdbuf_r <= {avm_readdata, rdbuf_r[111:16]};
                        ret_r   <= ret_r + 3'd1;
                        if (ret_r == 3'd7) begin
                            state_r    <= ACK;
                            req_ac     <= 1'b1;
                            req_rddata <= {avm_readdata, rdbuf_r};
                        end else begin
                            state_r <= RD_DRAIN;
                        end
                    end else begin
                        state_r <= RD_DRAIN;
                    end
                end
                ACK: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    avm_read  <= 1'b0;
                    avm_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_wide_port.sv
// Directed vector bench for sdram_wide_port with a small Avalon slave responder.
module tb_sdram_wide_port;

    logic         clk = 1'b0;
    logic         reset;
    logic [21:0]  req_addr;
    logic [15:0]  req_be;
    logic         req_read;
    logic         req_write;
    logic [127:0] req_wrdata;
    logic         req_ac;
    logic [127:0] req_rddata;
    logic [24:0]  avm_address;
    logic [1:0]   avm_byteenable;
    logic         avm_read;
    logic         avm_write;
    logic [15:0]  avm_writedata;
    logic [15:0]  avm_readdata;
    logic         avm_readdatavalid;
    logic         avm_waitrequest;

    sdram_wide_port dut (
        .clk(clk), .reset(reset),
        .req_addr(req_addr), .req_be(req_be), .req_read(req_read), .req_write(req_write),
        .req_wrdata(req_wrdata), .req_ac(req_ac), .req_rddata(req_rddata),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_wr;
        logic [21:0]  addr;
        logic [15:0]  be;
        logic [127:0] data;
        int           wait_beat;
        int           wait_n;
        int           lat;
        logic [15:0]  rd_base;
        int           exp_ack;
        logic [7:0]   exp_mask;
        logic [127:0] exp_rd;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int vi;
    vec_t cur;
    vec_t vecs[8];
    int due_q[$];
    logic [15:0] dat_q[$];
    int wait_left, held_cnt, ack_cnt, ack_k;
    logic [7:0] mask_got;
    logic [127:0] ack_rd, last_rd;
    logic hold_read, prev_wait;
    logic [24:0] prev_addr;
    logic [1:0] prev_be;
    logic [15:0] prev_wd;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL v%0d %s: got %0h want %0h", vi, nm, act, exp);
        end
    endtask

    // One cycle of slave behaviour, executed at the falling edge of cycle k.
    task automatic step(input int k);
        logic cmd;
        int b;
        if (prev_wait) begin
            chk("hold_addr", avm_address, prev_addr);
            chk("hold_be", avm_byteenable, prev_be);
            chk("hold_wdata", avm_writedata, prev_wd);
        end
        cmd = avm_read || avm_write;
        b = int'(avm_address[2:0]);
        avm_waitrequest = 1'b0;
        if (cmd && b == cur.wait_beat) begin
            held_cnt++;
            if (wait_left > 0) begin
                avm_waitrequest = 1'b1;
                wait_left--;
            end
        end
        if (cmd && !avm_waitrequest) begin
            mask_got[b] = 1'b1;
            chk("cmd_kind", avm_write, cur.is_wr);
            chk("addr_hi", avm_address[24:3], cur.addr);
            if (avm_write) begin
                chk($sformatf("wdata_b%0d", b), avm_writedata, cur.data[16*b +: 16]);
                chk($sformatf("be_b%0d", b), avm_byteenable, cur.be[2*b +: 2]);
            end else begin
                chk($sformatf("rd_be_b%0d", b), avm_byteenable, 2'b11);
                due_q.push_back(k + cur.lat);
                dat_q.push_back(cur.rd_base + 16'(b));
            end
        end
        prev_wait = avm_waitrequest;
        prev_addr = avm_address;
        prev_be   = avm_byteenable;
        prev_wd   = avm_writedata;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 16'h0000;
        if (due_q.size() > 0 && due_q[0] == k) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = dat_q[0];
            void'(due_q.pop_front());
            void'(dat_q.pop_front());
        end
        if (req_ac) begin
            ack_cnt++;
            if (ack_cnt == 1) begin
                ack_k  = k;
                ack_rd = req_rddata;
            end
            req_write = 1'b0;
            if (!hold_read) req_read = 1'b0;
        end
    endtask

    task automatic start_vec(input vec_t v, input logic chain);
        cur = v;
        due_q.delete();
        dat_q.delete();
        wait_left = v.wait_n;
        held_cnt  = 0;
        mask_got  = 8'h00;
        ack_cnt   = 0;
        ack_k     = -1;
        prev_wait = 1'b0;
        hold_read = chain;
        req_addr  = v.addr;
        if (v.is_wr) begin
            req_be     = v.be;
            req_wrdata = v.data;
            req_write  = 1'b1;
        end else begin
            req_read = 1'b1;
        end
    endtask

    // Request sampled at the next rising edge is cycle T; cycle T+k is checked at negedge k.
    task automatic run_vec(input vec_t v, input logic chain);
        start_vec(v, chain);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            step(k);
            if (ack_k > 0 && (chain || k >= ack_k + 2)) break;
        end
        chk("ack_cycle", 128'(ack_k), 128'(v.exp_ack));
        chk("ack_count", 128'(ack_cnt), 128'd1);
        chk("beat_mask", mask_got, v.exp_mask);
        if (!v.is_wr) begin
            chk("rddata", ack_rd, v.exp_rd);
            last_rd = v.exp_rd;
        end
        if (v.wait_n > 0) chk("held_cycles", 128'(held_cnt), 128'(v.wait_n + 1));
        if (!chain) chk("rddata_hold", req_rddata, last_rd);
    endtask

    initial begin
        int ack3, ack4, ack6;
        logic [7:0] m3, m4;
        vec_t rv;
        logic got4;
`ifdef WIDE_PORT_BE_SKIP_EN
        ack3 = 3;  m3 = 8'h0C;
        ack4 = 1;  m4 = 8'h00;
        ack6 = 8;
`else
        ack3 = 9;  m3 = 8'hFF;
        ack4 = 9;  m4 = 8'hFF;
        ack6 = 10;
`endif
        vecs[0] = '{1'b1, 22'h000010, 16'hFFFF, 128'h0007_0006_0005_0004_0003_0002_0001_0000,
                    -1, 0, 0, 16'h0000, 9, 8'hFF, 128'd0};
        vecs[1] = '{1'b0, 22'h3FFFFF, 16'h0000, 128'd0, -1, 0, 3, 16'hA000, 12, 8'hFF,
                    128'hA007_A006_A005_A004_A003_A002_A001_A000};
        vecs[2] = '{1'b1, 22'h0ABCDE, 16'hFFFF, 128'h1111_2222_3333_4444_5555_6666_7777_8888,
                    3, 2, 0, 16'h0000, 11, 8'hFF, 128'd0};
        vecs[3] = '{1'b1, 22'h001234, 16'h00F0, 128'h8765_4321_0FED_CBA9_DEAD_BEEF_CAFE_F00D,
                    -1, 0, 0, 16'h0000, ack3, m3, 128'd0};
        vecs[4] = '{1'b1, 22'h000777, 16'h0000, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF,
                    -1, 0, 0, 16'h0000, ack4, m4, 128'd0};
        vecs[5] = '{1'b0, 22'h000000, 16'h0000, 128'd0, 5, 1, 1, 16'h1230, 11, 8'hFF,
                    128'h1237_1236_1235_1234_1233_1232_1231_1230};
        vecs[6] = '{1'b1, 22'h2AAAAA, 16'hA5C3, 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978,
                    4, 1, 0, 16'h0000, ack6, 8'hFF, 128'd0};
`ifdef WIDE_PORT_BE_SKIP_EN
        vecs[6].exp_mask = 8'hF9;
`endif
        vecs[7] = '{1'b0, 22'h155555, 16'h0000, 128'd0, -1, 0, 0, 16'h5550, 9, 8'hFF,
                    128'h5557_5556_5555_5554_5553_5552_5551_5550};

        vi = -1;
        reset = 1'b1;
        req_addr = 22'd0; req_be = 16'd0; req_read = 1'b0; req_write = 1'b0; req_wrdata = 128'd0;
        avm_readdata = 16'd0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
        hold_read = 1'b0; last_rd = 128'd0;
        repeat (2) @(negedge clk);
        chk("rst_ac", req_ac, 1'b0);
        chk("rst_rd", avm_read, 1'b0);
        chk("rst_wr", avm_write, 1'b0);
        chk("rst_addr", avm_address, 25'd0);
        chk("rst_be", avm_byteenable, 2'b00);
        chk("rst_wdata", avm_writedata, 16'd0);
        chk("rst_rddata", req_rddata, 128'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            vi = i;
            run_vec(vecs[i], 1'b0);
        end

        // Simultaneous read and write: write first, held read taken in the IDLE after ACK.
        vi = 8;
        req_read = 1'b1;
        run_vec('{1'b1, 22'h000300, 16'hFFFF, 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878,
                  -1, 0, 0, 16'h0000, 9, 8'hFF, 128'd0}, 1'b1);
        vi = 9;
        run_vec('{1'b0, 22'h000300, 16'h0000, 128'd0, -1, 0, 2, 16'hC000, 12, 8'hFF,
                  128'hC007_C006_C005_C004_C003_C002_C001_C000}, 1'b0);

        // Reset while read beat 4 is on the bus, then late read data must be ignored.
        vi = 10;
        rv = '{1'b0, 22'h000123, 16'h0000, 128'd0, -1, 0, 3, 16'hB000, 12, 8'hFF,
               128'hB007_B006_B005_B004_B003_B002_B001_B000};
        start_vec(rv, 1'b0);
        got4 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (avm_read && avm_address[2:0] == 3'd4) begin
                got4 = 1'b1;
                break;
            end
            step(k);
        end
        chk("rst_reached_beat4", got4, 1'b1);
        reset = 1'b1;
        req_read = 1'b0;
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ac", req_ac, 1'b0);
        chk("abort_rd", avm_read, 1'b0);
        chk("abort_addr", avm_address, 25'd0);
        chk("abort_be", avm_byteenable, 2'b00);
        chk("abort_rddata", req_rddata, 128'd0);
        chk("abort_no_ack_before", 128'(ack_cnt), 128'd0);
        for (int i = 0; i < 4; i++) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = 16'hDEAD;
            @(negedge clk);
            chk($sformatf("late_rdv%0d_ac", i), req_ac, 1'b0);
            chk($sformatf("late_rdv%0d_rd", i), avm_read, 1'b0);
        end
        avm_readdatavalid = 1'b0;
        avm_readdata = 16'h0000;
        chk("late_rddata", req_rddata, 128'd0);
        last_rd = 128'd0;
        vi = 11;
        run_vec(rv, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_wide_port.md
SDRAM_WIDE_PORT -- requirements
Module: sdram_wide_port

Interface
REQ-001 clk  input  1  system clock; all logic on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 req_addr  input  22  128-bit word address from arbiter.
REQ-004 req_be  input  16  byte enables for the 128-bit word; bit i = byte i.
REQ-005 req_read  input  1  read request; held by requester until req_ac.
REQ-006 req_write  input  1  write request; held by requester until req_ac.
REQ-007 req_wrdata  input  128  write data; bits[15:0] = lowest halfword.
REQ-008 req_ac  output  1  one-cycle acknowledge; transaction complete.
REQ-009 req_rddata  output  128  assembled read data; valid in req_ac cycle of a read.
REQ-010 avm_address  output  25  halfword address = {req_addr, beat[2:0]}.
REQ-011 avm_byteenable  output  2  beat byte enables = req_be[2*beat+1 : 2*beat].
REQ-012 avm_read / avm_write  output  1 each  Avalon-MM read / write strobes.
REQ-013 avm_writedata  output  16  = req_wrdata[16*beat+15 : 16*beat].
REQ-014 avm_readdata  input  16  returned halfword.
REQ-015 avm_readdatavalid  input  1  pipelined read-data strobe.
REQ-016 avm_waitrequest  input  1  slave stall; command held while high.

Function
REQ-017 The block SHALL implement states IDLE, WR_BEAT, RD_ISSUE, RD_DRAIN, ACK.
REQ-018 In IDLE, a cycle with req_write=1 SHALL latch addr/be/wrdata and go to WR_BEAT with beat=0; req_write SHALL win over simultaneous req_read.
REQ-019 In IDLE, req_read=1 with req_write=0 SHALL latch addr and go to RD_ISSUE with issue and return counters = 0.
REQ-020 In WR_BEAT, avm_write=1; beat SHALL advance only in cycles with avm_waitrequest=0; acceptance of beat 7 SHALL move to ACK.
REQ-021 In RD_ISSUE, avm_read=1 with avm_byteenable=2'b11; issue counter SHALL advance on waitrequest=0; acceptance of beat 7 SHALL move to RD_DRAIN.
REQ-022 Each avm_readdatavalid in RD_ISSUE or RD_DRAIN SHALL write avm_readdata into halfword[return counter] of the read register and increment the return counter.
REQ-023 When the 8th halfword has been captured (in RD_ISSUE or RD_DRAIN), the block SHALL enter ACK on the next cycle.
REQ-024 ACK SHALL last exactly one cycle with req_ac=1, then return to IDLE; requests are not sampled during ACK.
REQ-025 avm_address, avm_byteenable and avm_writedata SHALL be stable while avm_waitrequest=1.
REQ-026 avm_readdatavalid in IDLE, WR_BEAT or ACK SHALL be ignored.
REQ-027 req_rddata SHALL hold its last assembled value outside ACK.
REQ-028 Latency with no waitrequest: request sampled at cycle T, beats T+1..T+8, write req_ac at T+9; read req_ac one cycle after the 8th readdatavalid.
REQ-029 Beat counter SHALL be 3 bits and SHALL NOT wrap past 7 within one transaction.

Reset
REQ-030 Reset SHALL force IDLE and drive req_ac, avm_read, avm_write, avm_byteenable, avm_address, avm_writedata and req_rddata to 0, clearing all counters.
REQ-031 Reset during WR_BEAT, RD_ISSUE or RD_DRAIN SHALL abort the transaction without req_ac; outstanding read data arriving afterwards SHALL be ignored (REQ-026).

Configuration
REQ-032 With WIDE_PORT_BE_SKIP_EN defined, write beats whose two byte enables are 00 SHALL be skipped with no bus cycle; a write with req_be=0 SHALL produce req_ac at T+1 (IDLE->ACK).
REQ-033 Without WIDE_PORT_BE_SKIP_EN, all 8 write beats SHALL be issued regardless of req_be; reads always issue 8 beats in both builds.

Verification
REQ-034 Write addr=22'h000010, be=FFFF, data=128'h0007_0006_..._0000, waitrequest=0 -> avm_address 0x80..0x87, writedata 0..7, req_ac at T+9.
REQ-035 Read addr=22'h3FFFFF, slave returns 16'hA000+i with latency 3 -> avm_address 0x1FFFFF8..0x1FFFFFF, req_rddata={A007,...,A000}, single req_ac.
REQ-036 Write with waitrequest high 2 cycles on beat 3 -> beat-3 address/data/byteenable held 3 cycles, req_ac at T+11.
REQ-037 req_read=req_write=1 in same cycle -> write executed, then (request held) read accepted in the IDLE after ACK.
REQ-038 Reset asserted at read beat 4, 4 late readdatavalids follow -> no req_ac, outputs 0, next read returns correct data.
REQ-039 WIDE_PORT_BE_SKIP_EN, be=16'h00F0 -> only beats 2,3 issued, req_ac at T+3; without macro -> 8 beats, byteenable 00 except beats 2,3.
